// File: rtl/pcpi_ser_pkg.sv
// rtl/pcpi_ser_pkg.sv - shared state encoding and default widths for the PCPI result serializer
package pcpi_ser_pkg;

  localparam int SER_DATA_W = 32;
  localparam int SER_SEG_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } ser_state_t;

endpackage

// File: rtl/pcpi_result_serializer.sv
// rtl/pcpi_result_serializer.sv - captures a PCPI write-back result and presents it to a host one nibble at a time
module pcpi_result_serializer
  import pcpi_ser_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W,
  parameter int SEG_W  = SER_SEG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pcpi_ready,
  input  logic              pcpi_wr,
  input  logic [DATA_W-1:0] pcpi_rd,
  input  logic              nib_ack,
  output logic [SEG_W-1:0]  nib_data,
  output logic              nib_valid,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              overrun
);

  localparam int NSEG  = DATA_W / SEG_W;
  localparam int CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  ser_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] shadow_q;
  logic              overrun_q;
  logic              take;
  logic              last_seg;

  // A result is only worth serializing when it carries a register write.
  assign take     = pcpi_ready & pcpi_wr;
  assign last_seg = (count_q == CNT_W'(NSEG - 1));

  // Next-state and output decode; outputs depend on the registered state only.
  always_comb begin
    state_d   = state_q;
    nib_valid = 1'b0;
    nib_data  = '0;
    tx_busy   = (state_q != ST_IDLE);
    tx_done   = 1'b0;
    overrun   = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (take) state_d = ST_SEND;
      end
      ST_SEND: begin
        nib_valid = 1'b1;
        nib_data  = shadow_q[int'(count_q)*SEG_W +: SEG_W];
        if (nib_ack) state_d = last_seg ? ST_DONE : ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_SEND;
      end
      ST_DONE: begin
        tx_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shadow capture, segment counter and sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      shadow_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            shadow_q <= pcpi_rd;
            count_q  <= '0;
          end
        end
        ST_SEND: begin
          // The last segment leaves the count alone; DONE clears it.
          if (nib_ack && !last_seg) count_q <= count_q + 1'b1;
        end
        ST_DONE: count_q <= '0;
        default: ;
      endcase
      // A new result while a frame is in flight is dropped, never queued.
      if (take && (state_q != ST_IDLE)) overrun_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pcpi_result_serializer.sv
// tb/tb_pcpi_result_serializer.sv - randomized and directed self-checking bench for pcpi_result_serializer
module tb_pcpi_result_serializer;

  localparam int DATA_W = 32;
  localparam int SEG_W  = 4;
  localparam int NSEG   = DATA_W / SEG_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pcpi_ready;
  logic              pcpi_wr;
  logic [DATA_W-1:0] pcpi_rd;
  logic              nib_ack;
  logic [SEG_W-1:0]  nib_data;
  logic              nib_valid;
  logic              tx_busy;
  logic              tx_done;
  logic              overrun;

  int n_vec = 0;
  int n_err = 0;

  // Reference: nibbles still owed to the host, plus the one-cycle gap / done phases.
  int m_q[$];
  bit m_gap;
  bit m_done;
  bit m_over;

  pcpi_result_serializer #(.DATA_W(DATA_W), .SEG_W(SEG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pcpi_ready (pcpi_ready),
    .pcpi_wr    (pcpi_wr),
    .pcpi_rd    (pcpi_rd),
    .nib_ack    (nib_ack),
    .nib_data   (nib_data),
    .nib_valid  (nib_valid),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_busy();
    return (m_q.size() != 0) || m_gap || m_done;
  endfunction

  task automatic compare_outputs();
    bit ev;
    ev = !m_done && !m_gap && (m_q.size() != 0);
    check("nib_valid", 32'(nib_valid), 32'(ev));
    if (ev) check("nib_data", 32'(nib_data), 32'(m_q[0]));
    check("tx_busy", 32'(tx_busy), 32'(m_busy()));
    check("tx_done", 32'(tx_done), 32'(m_done));
    check("overrun", 32'(overrun), 32'(m_over));
  endtask

  // One clock cycle: drive, compare, clock, advance the reference.
  task automatic cycle(input bit rdy, input bit wr, input logic [31:0] rd, input bit ack);
    bit idle;
    pcpi_ready = rdy;
    pcpi_wr    = wr;
    pcpi_rd    = rd;
    nib_ack    = ack;
    #3;
    compare_outputs();
    @(posedge clk);
    idle = !m_busy();
    if (m_done) m_done = 0;
    else if (m_gap) m_gap = 0;
    else if (m_q.size() != 0 && ack) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_done = 1;
      else m_gap = 1;
    end
    if (rdy && wr) begin
      if (idle) for (int i = 0; i < NSEG; i++) m_q.push_back(int'((rd >> (SEG_W * i)) & 32'hF));
      else m_over = 1;
    end
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit ack);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, ack);
  endtask

  task automatic async_reset();
    pcpi_ready = 0;
    pcpi_wr    = 0;
    nib_ack    = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_nib_valid", 32'(nib_valid), 32'h0);
    check("rst_nib_data", 32'(nib_data), 32'h0);
    check("rst_tx_busy", 32'(tx_busy), 32'h0);
    check("rst_tx_done", 32'(tx_done), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    m_q.delete();
    m_gap  = 0;
    m_done = 0;
    m_over = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int done_at;
    int prev;
    rst_n      = 1'b0;
    pcpi_ready = 0;
    pcpi_wr    = 0;
    pcpi_rd    = '0;
    nib_ack    = 0;
    m_gap = 0; m_done = 0; m_over = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_nib_valid", 32'(nib_valid), 32'h0);
    check("reset_nib_data", 32'(nib_data), 32'h0);
    check("reset_tx_busy", 32'(tx_busy), 32'h0);
    check("reset_tx_done", 32'(tx_done), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    idle_cycles(2, 0);

    // Full frame with ack held high: tx_done exactly 2*NSEG cycles after capture.
    cycle(1, 1, 32'h89ABCDEF, 1);
    done_at = -1;
    for (int k = 1; k <= 20; k++) begin
      if (tx_done && done_at < 0) done_at = k;
      cycle(0, 0, 32'h0, 1);
    end
    check("latency_tx_done", 32'(done_at), 32'(2 * NSEG));

    // Stall on nibble 2 for five cycles.
    cycle(1, 1, 32'h12345678, 1);
    idle_cycles(4, 1);
    for (int k = 0; k < 5; k++) begin
      check("stall_data", 32'(nib_data), 32'h6);
      cycle(0, 0, 32'h0, 0);
    end
    idle_cycles(14, 1);

    // Result without a register write is ignored.
    cycle(1, 0, 32'hFFFFFFFF, 1);
    idle_cycles(3, 1);

    // Second result mid-frame is dropped and flagged.
    cycle(1, 1, 32'h00000011, 1);
    idle_cycles(2, 1);
    cycle(1, 1, 32'hDEADBEEF, 1);
    idle_cycles(16, 1);
    check("overrun_sticky", 32'(overrun), 32'h1);

    // Reset after nibble 3, then a fresh frame restarts at nibble 0.
    cycle(1, 1, 32'h87654321, 1);
    idle_cycles(6, 1);
    async_reset();
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      prev |= int'(tx_done);
      cycle(0, 0, 32'h0, 1);
    end
    check("no_done_after_reset", 32'(prev), 32'h0);
    cycle(1, 1, 32'h0000000A, 0);
    check("first_after_reset", 32'(nib_data), 32'hA);
    idle_cycles(20, 1);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      cycle(($urandom_range(0, 7) == 0), $urandom_range(0, 1), $urandom, ($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    idle_cycles(40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pcpi_result_serializer.md
PCPI_RESULT_SERIALIZER -- requirements
Module: pcpi_result_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: result width in bits.
REQ-002 SHALL have parameter SEG_W, default 4: nibble width; DATA_W SHALL be an integer multiple of SEG_W.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port pcpi_ready  input  1  coprocessor result strobe.
REQ-006 SHALL have port pcpi_wr  input  1  result carries a register write.
REQ-007 SHALL have port pcpi_rd  input  DATA_W  coprocessor result value.
REQ-008 SHALL have port nib_ack  input  1  host accepts the presented nibble.
REQ-009 SHALL have port nib_data  output  SEG_W  nibble presented to host.
REQ-010 SHALL have port nib_valid  output  1  nib_data valid.
REQ-011 SHALL have port tx_busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse after last nibble transfers.
REQ-013 SHALL have port overrun  output  1  sticky: a result was dropped.

Function
REQ-014 SHALL implement states IDLE, SEND, GAP, DONE; NSEG = DATA_W/SEG_W.
REQ-015 IDLE: on pcpi_ready=1 and pcpi_wr=1 SHALL latch pcpi_rd into shadow register, clear segment count, go to SEND next cycle.
REQ-016 IDLE: pcpi_ready=1 with pcpi_wr=0 SHALL be ignored (no capture, no flag).
REQ-017 SEND: nib_valid=1, nib_data = shadow[SEG_W*count +: SEG_W], LSB nibble first; nib_data SHALL hold stable until transfer.
REQ-018 Transfer occurs in a SEND cycle where nib_ack=1; nib_ack in any other state SHALL be ignored.
REQ-019 On transfer with count < NSEG-1: count increments, next state GAP (nib_valid=0 for exactly one cycle), then SEND.
REQ-020 On transfer with count = NSEG-1: next state DONE; DONE asserts tx_done for one cycle, clears count, returns to IDLE.
REQ-021 Latency: first nibble valid 1 cycle after capture; with nib_ack held high each nibble occupies 2 cycles; tx_done 2*NSEG cycles after capture.
REQ-022 SEND with nib_ack=0 SHALL hold indefinitely (no timeout).
REQ-023 pcpi_ready=1 and pcpi_wr=1 in any non-IDLE state SHALL be dropped, SHALL set overrun, SHALL NOT disturb shadow, count or state.
REQ-024 overrun SHALL remain set until reset.
REQ-025 Count SHALL never exceed NSEG-1; no wrap-around into a second frame without a new capture.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, count 0, shadow 0, nib_valid 0, nib_data 0, tx_busy 0, tx_done 0, overrun 0.
REQ-027 Reset mid-frame SHALL abandon the frame; no tx_done SHALL follow; first capture after release starts at nibble 0.

Structure
REQ-028 Shared package pcpi_ser_pkg SHALL hold the state enum and SEG_W/DATA_W default constants.
REQ-029 Single module, no sub-module; nibble select is an indexed part-select of the shadow register.

Verification
REQ-030 pcpi_rd=0x89ABCDEF, wr=1, nib_ack held 1 -> nibbles F,E,D,C,B,A,9,8 at cycles 1,3,...,15 after capture, tx_done at cycle 16, tx_busy low at 17.
REQ-031 pcpi_rd=0x12345678, nib_ack withheld 5 cycles on nibble 2 -> nib_data=6 stable and nib_valid=1 through stall, sequence resumes 5,4,3,2,1.
REQ-032 pcpi_ready=1 with pcpi_wr=0, pcpi_rd=0xFFFFFFFF -> nib_valid and tx_busy stay 0, overrun stays 0.
REQ-033 Second pcpi_ready/wr=1 (rd=0xDEADBEEF) during frame of 0x00000011 -> overrun=1, output stays 1,1,0,0,0,0,0,0.
REQ-034 rst_n pulsed low after nibble 3 -> all outputs 0 asynchronously, no tx_done; new capture of 0x0000000A sends A first.
REQ-035 nib_ack=1 during GAP and IDLE cycles -> no extra transfers, count unchanged.
